// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates two command requesters (0 = SPI slave, 1 = local host)
// onto a single RAM command port, with round-robin tie-breaking, address/read
// locking, read-response routing and an ownership timeout.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_data[9:0]             command word: [9:8] opcode, [7:0] address/data
//   reqN_valid / reqN_ready    command handshake (ready is combinational)
//   rspN_data[7:0], rspN_valid read data returned to the owning requester
//   ram_din[9:0], ram_rx_valid command forwarded to the RAM, one cycle later
//   ram_dout[7:0], ram_tx_valid RAM read data
//   timeout_err                one-cycle pulse when ownership is force-released
//
// Opcodes: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_valid,
  input  logic [9:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] rsp1_data,
  output logic       rsp1_valid,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       owner;
  logic       last_grant;
  logic       sel;
  logic       accept;
  logic       expired;
  logic       rsp_fire;
  logic       to_fire;
  logic [7:0] timer, timer_nxt;
  logic [8:0] timer_inc;
  logic [9:0] acc_data;

  // Grant / ready generation.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sel        = owner;
    case (state)
      IDLE: begin
        // On a tie the requester not granted last wins; otherwise the lone
        // valid requester (sel=0 when neither is valid, readys stay 0).
        if (req0_valid && req1_valid) sel = ~last_grant;
        else                          sel = req1_valid;
        req0_ready = req0_valid & ~sel;
        req1_ready = req1_valid &  sel;
      end
      LOCKED: begin
        // Owner's ready does not depend on its valid.
        req0_ready = ~owner;
        req1_ready =  owner;
      end
      default: ;
    endcase
  end

  assign accept    = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  assign acc_data  = sel ? req1_data : req0_data;
  assign timer_inc = {1'b0, timer} + 9'd1;
  assign expired   = (timer_inc == 9'(TIMEOUT));

  // Next state. A read response beats a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    rsp_fire  = 1'b0;
    to_fire   = 1'b0;
    if (state == LOCKED || state == WAIT_RD) timer_nxt = timer_inc[7:0];
    if (accept) begin
      timer_nxt = '0;
      case (acc_data[9:8])
        2'b01:   state_nxt = IDLE;
        2'b11:   state_nxt = WAIT_RD;
        default: state_nxt = LOCKED;
      endcase
    end else if (state == WAIT_RD && ram_tx_valid) begin
      state_nxt = IDLE;
      rsp_fire  = 1'b1;
      timer_nxt = '0;
    end else if (state != IDLE && expired) begin
      state_nxt = IDLE;
      to_fire   = 1'b1;
      timer_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      timer        <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp0_data    <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_data    <= '0;
      rsp1_valid   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      ram_rx_valid <= accept;
      timeout_err  <= to_fire;
      rsp0_valid   <= rsp_fire & ~owner;
      rsp1_valid   <= rsp_fire &  owner;
      if (accept) begin
        owner      <= sel;
        last_grant <= sel;
        ram_din    <= acc_data;
      end
      if (rsp_fire) begin
        if (owner) rsp1_data <= ram_dout;
        else       rsp0_data <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter (TIMEOUT=16).
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [9:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_valid, rsp1_valid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       timeout_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ram_arbiter #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_data    (req0_data),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .rsp0_data    (rsp0_data),
    .rsp0_valid   (rsp0_valid),
    .req1_data    (req1_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .rsp1_data    (rsp1_data),
    .rsp1_valid   (rsp1_valid),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    req0_data    = '0;
    req1_data    = '0;
    ram_tx_valid = 1'b0;
    ram_dout     = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_din"}, 32'(ram_din), 32'h0);
    check({tag, "_rx_valid"}, 32'(ram_rx_valid), 32'h0);
    check({tag, "_rsp0_data"}, 32'(rsp0_data), 32'h0);
    check({tag, "_rsp1_data"}, 32'(rsp1_data), 32'h0);
    check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'h0);
    check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'h0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset_rdy0", 32'(req0_ready), 32'h0);
    check("reset_rdy1", 32'(req1_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write pair from req0.
    req0_valid = 1'b1; req0_data = 10'h005;
    #1;
    check("wr_rdy0_a", 32'(req0_ready), 32'h1);
    tick();
    check("wr_din_a", 32'(ram_din), 32'h005);
    check("wr_rx_a", 32'(ram_rx_valid), 32'h1);
    req0_data = 10'h1AA; req1_valid = 1'b1; req1_data = 10'h1FF;
    #1;
    check("wr_rdy1_locked", 32'(req1_ready), 32'h0);
    check("wr_rdy0_locked", 32'(req0_ready), 32'h1);
    tick();
    check("wr_din_b", 32'(ram_din), 32'h1AA);
    check("wr_rx_b", 32'(ram_rx_valid), 32'h1);
    req0_valid = 1'b0;
    #1;
    check("wr_idle_rdy1", 32'(req1_ready), 32'h1);
    req1_valid = 1'b0;
    tick();
    check("wr_rx_idle", 32'(ram_rx_valid), 32'h0);

    // Read pair from req1, RAM returns 0xAA.
    req1_valid = 1'b1; req1_data = 10'h205;
    #1;
    check("rd_rdy1_a", 32'(req1_ready), 32'h1);
    tick();
    check("rd_din_a", 32'(ram_din), 32'h205);
    req1_data = 10'h300;
    tick();
    check("rd_din_b", 32'(ram_din), 32'h300);
    check("rd_rx_b", 32'(ram_rx_valid), 32'h1);
    req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 10'h101;
    #1;
    check("rd_wait_rdy0", 32'(req0_ready), 32'h0);
    check("rd_wait_rdy1", 32'(req1_ready), 32'h0);
    req0_valid = 1'b0;
    tick();
    check("rd_no_early_rsp", 32'(rsp1_valid), 32'h0);
    ram_tx_valid = 1'b1; ram_dout = 8'hAA;
    tick();
    ram_tx_valid = 1'b0;
    check("rd_rsp1_valid", 32'(rsp1_valid), 32'h1);
    check("rd_rsp1_data", 32'(rsp1_data), 32'hAA);
    check("rd_rsp0_quiet", 32'(rsp0_valid), 32'h0);
    tick();
    check("rd_rsp1_once", 32'(rsp1_valid), 32'h0);
    check("rd_rsp1_hold", 32'(rsp1_data), 32'hAA);
    ram_tx_valid = 1'b1; ram_dout = 8'h55;
    tick();
    ram_tx_valid = 1'b0;
    check("stray_tx_rsp0", 32'(rsp0_valid), 32'h0);
    check("stray_tx_rsp1", 32'(rsp1_valid), 32'h0);
    check("stray_tx_hold", 32'(rsp1_data), 32'hAA);

    // Round-robin tie out of reset.
    do_reset();
    req0_valid = 1'b1; req0_data = 10'h101;
    req1_valid = 1'b1; req1_data = 10'h102;
    #1;
    check("tie1_rdy0", 32'(req0_ready), 32'h1);
    check("tie1_rdy1", 32'(req1_ready), 32'h0);
    tick();
    check("tie1_din", 32'(ram_din), 32'h101);
    check("tie2_rdy0", 32'(req0_ready), 32'h0);
    check("tie2_rdy1", 32'(req1_ready), 32'h1);
    tick();
    check("tie2_din", 32'(ram_din), 32'h102);
    check("tie3_rdy0", 32'(req0_ready), 32'h1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Timeout in LOCKED.
    req0_valid = 1'b1; req0_data = 10'h010;
    tick();
    check("to_din", 32'(ram_din), 32'h010);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 10'h1BB;
    for (int unsigned i = 1; i < 16; i++) begin
      tick();
      check($sformatf("to_err_c%0d", i), 32'(timeout_err), 32'h0);
      check($sformatf("to_rx_c%0d", i), 32'(ram_rx_valid), 32'h0);
      check($sformatf("to_rdy1_c%0d", i), 32'(req1_ready), 32'h0);
    end
    tick();
    check("to_err_pulse", 32'(timeout_err), 32'h1);
    check("to_rx_quiet", 32'(ram_rx_valid), 32'h0);
    check("to_rdy1_free", 32'(req1_ready), 32'h1);
    tick();
    check("to_err_once", 32'(timeout_err), 32'h0);
    check("to_req1_din", 32'(ram_din), 32'h1BB);
    check("to_req1_rx", 32'(ram_rx_valid), 32'h1);
    req1_valid = 1'b0;
    tick();

    // Late read response after timeout.
    req0_valid = 1'b1; req0_data = 10'h300;
    tick();
    req0_valid = 1'b0;
    repeat (15) tick();
    check("late_err_early", 32'(timeout_err), 32'h0);
    tick();
    check("late_err_pulse", 32'(timeout_err), 32'h1);
    ram_tx_valid = 1'b1; ram_dout = 8'h77;
    tick();
    ram_tx_valid = 1'b0;
    check("late_rsp0", 32'(rsp0_valid), 32'h0);
    check("late_rsp1", 32'(rsp1_valid), 32'h0);
    check("late_err_once", 32'(timeout_err), 32'h0);

    // Response coinciding with the timeout boundary is delivered.
    req0_valid = 1'b1; req0_data = 10'h300;
    tick();
    req0_valid = 1'b0;
    repeat (15) tick();
    ram_tx_valid = 1'b1; ram_dout = 8'h3C;
    tick();
    ram_tx_valid = 1'b0;
    check("edge_rsp0_valid", 32'(rsp0_valid), 32'h1);
    check("edge_rsp0_data", 32'(rsp0_data), 32'h3C);
    check("edge_no_err", 32'(timeout_err), 32'h0);
    tick();

    // Reset mid-LOCKED.
    req0_valid = 1'b1; req0_data = 10'h210;
    tick();
    req0_valid = 1'b0;
    check("rl_din", 32'(ram_din), 32'h210);
    rst_n = 1'b0;
    #1;
    check_all_zero("rl_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 10'h101;
    req1_valid = 1'b1; req1_data = 10'h1CC;
    #1;
    check("rl_tie_rdy0", 32'(req0_ready), 32'h1);
    check("rl_tie_rdy1", 32'(req1_ready), 32'h0);
    req0_valid = 1'b0;
    #1;
    check("rl_lone_rdy1", 32'(req1_ready), 32'h1);
    tick();
    req1_valid = 1'b0;
    check("rl_lone_din", 32'(ram_din), 32'h1CC);
    tick();

    // Reset mid-WAIT_RD: the late response must be dropped.
    req0_valid = 1'b1; req0_data = 10'h300;
    tick();
    req0_valid = 1'b0;
    do_reset();
    ram_tx_valid = 1'b1; ram_dout = 8'h99;
    tick();
    ram_tx_valid = 1'b0;
    check("rw_rsp0", 32'(rsp0_valid), 32'h0);
    check("rw_rsp0_data", 32'(rsp0_data), 32'h0);
    check("rw_rsp1", 32'(rsp1_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
